// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scan, row debounce and key decode.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_TICKS ticks while a key is held.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 5,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_shift_reg,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pressed
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  // codes indexed by {column position, row position}, position 0 = bit 3
  localparam logic [63:0] LUT = 64'hDF0EC987B654A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state;
  logic [3:0] row_m, row_s, row_cap, rot, code;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, cnt_inc;
  logic tick, one_hot, cnt_done;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep;
  logic rep_done;
  assign rep_done = rep == RW'(REPEAT_TICKS - 1);
`endif
  function automatic logic [1:0] pos(input logic [3:0] v);
    return v[3] ? 2'd0 : v[2] ? 2'd1 : v[1] ? 2'd2 : 2'd3;
  endfunction
  assign tick     = div == DW'(SCAN_DIV - 1);
  assign one_hot  = row_s != 4'h0 && (row_s & (row_s - 4'h1)) == 4'h0;
  assign cnt_inc  = cnt == CW'(DEBOUNCE_CNT) ? cnt : cnt + 1'b1;
  assign cnt_done = cnt_inc == CW'(DEBOUNCE_CNT);
  assign rot      = {col_shift_reg[0], col_shift_reg[3:1]};
  assign code     = LUT[{pos(col_shift_reg), pos(row_cap), 2'b00} +: 4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= SCAN;
      row_m         <= '0;
      row_s         <= '0;
      row_cap       <= '0;
      div           <= '0;
      cnt           <= '0;
      col_shift_reg <= 4'b1000;
      key_value     <= '0;
      key_valid     <= 1'b0;
      key_pressed   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep           <= '0;
`endif
    end else begin
      row_m     <= row_in;
      row_s     <= row_m;
      div       <= tick ? '0 : div + 1'b1;
      key_valid <= 1'b0;
      if (tick)
        case (state)
          SCAN:
            if (one_hot) begin
              row_cap <= row_s;
              cnt     <= '0;
              state   <= DEBOUNCE;
            end else
              col_shift_reg <= rot;
          DEBOUNCE:
            if (row_s != row_cap) begin
              col_shift_reg <= rot;
              state         <= SCAN;
            end else begin
              cnt <= cnt_inc;
              if (cnt_done) begin
                key_value   <= code;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
                state       <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                rep         <= '0;
`endif
              end
            end
          PRESSED:
            if (row_s == 4'h0) begin
              cnt   <= '0;
              state <= RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else begin
              rep       <= rep_done ? '0 : rep + 1'b1;
              key_valid <= rep_done;
            end
`endif
          RELEASE:
            if (row_s != 4'h0) begin
              state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep   <= '0;
`endif
            end else begin
              cnt <= cnt_inc;
              if (cnt_done) begin
                key_pressed   <= 1'b0;
                col_shift_reg <= rot;
                state         <= SCAN;
              end
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: scoreboard bench driving a modelled keypad into keypad_scan_ctrl.
module tb_keypad_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] row_in, col_shift_reg, key_value;
  logic key_valid, key_pressed;
  logic k_on = 1'b0, raw = 1'b0;
  logic [3:0] k_col = 4'h0, k_row = 4'h0, raw_row = 4'h0, e_mon, c0, ec;
  int errors = 0, checks = 0, n_valid = 0, nv0;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_TICKS(5)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_shift_reg(col_shift_reg),
    .key_value(key_value), .key_valid(key_valid), .key_pressed(key_pressed));

  always #5 clk = ~clk;
  // pressed key shorts its row onto the strobed column; raw mode overrides the pins
  always_comb row_in = raw ? raw_row : (k_on && col_shift_reg == k_col) ? k_row : 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (key_valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got key_value %0h expected no pulse", key_value);
      end else begin
        e_mon = exp_q.pop_front();
        if (key_value !== e_mon || key_pressed !== 1'b1) begin
          errors++;
          $display("FAIL valid_value: got %0h/pressed %0b expected %0h/pressed 1", key_value, key_pressed, e_mon);
        end
      end
    end

  task automatic wait_pressed(input logic v, input string name);
    int n = 0;
    while (key_pressed !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, key_pressed, v);
  endtask

  task automatic press(input logic [3:0] c, input logic [3:0] r, input logic [3:0] e, input int hold);
    exp_q.push_back(e);
    k_col = c;
    k_row = r;
    k_on  = 1'b1;
    wait_pressed(1'b1, "press");
    check("frozen_col", col_shift_reg, c);
    check("key_value", key_value, e);
    repeat (hold) @(negedge clk);
    check("held_col", col_shift_reg, c);
    k_on = 1'b0;
    wait_pressed(1'b0, "release");
    check("resume_col", col_shift_reg, {c[0], c[3:1]});
  endtask

  initial begin
    @(negedge clk);
    check("rst_col", col_shift_reg, 4'b1000);
    check("rst_value", key_value, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_pressed", key_pressed, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ec = 4'b1000 >> ((k / 4) % 4);
      check("idle_col", col_shift_reg, ec);
      check("idle_flags", {key_valid, key_pressed}, 2'b00);
    end
    press(4'b0100, 4'b0100, 4'h5, 12);
    press(4'b0001, 4'b0100, 4'h0, 8);
    press(4'b0001, 4'b0010, 4'hF, 8);
    press(4'b1000, 4'b0001, 4'hA, 8);
    // one-tick row pulse must be rejected by the debounce
    nv0 = n_valid;
    raw = 1'b1;
    raw_row = 4'b0010;
    repeat (4) @(negedge clk);
    raw_row = 4'h0;
    repeat (40) @(negedge clk);
    check("pulse_pressed", key_pressed, 1'b0);
    check("pulse_no_valid", n_valid, nv0);
    // two rows at once is not a key
    raw_row = 4'b1100;
    repeat (4) @(negedge clk);
    c0 = col_shift_reg;
    repeat (8) @(negedge clk);
    check("multi_rotates", col_shift_reg != c0, 1'b1);
    repeat (20) @(negedge clk);
    check("multi_pressed", key_pressed, 1'b0);
    check("multi_no_valid", n_valid, nv0);
    raw = 1'b0;
    raw_row = 4'h0;
    // glitch to zero for one tick while held
    exp_q.push_back(4'h8);
    k_col = 4'b0010;
    k_row = 4'b0100;
    k_on = 1'b1;
    wait_pressed(1'b1, "glitch_press");
    check("glitch_value", key_value, 4'h8);
    repeat (4) @(negedge clk);
    raw = 1'b1;
    repeat (4) @(negedge clk);
    raw = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_held", key_pressed, 1'b1);
    check("glitch_one_valid", n_valid, nv0 + 1);
    k_on = 1'b0;
    wait_pressed(1'b0, "glitch_release");
    // reset in the middle of a debounce
    for (int n = 0; n < 64 && col_shift_reg == 4'b1000; n++) @(negedge clk);
    for (int n = 0; n < 64 && col_shift_reg != 4'b1000; n++) @(negedge clk);
    k_col = 4'b1000;
    k_row = 4'b0010;
    k_on = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_col", col_shift_reg, 4'b1000);
    check("arst_value", key_value, 4'h0);
    check("arst_valid", key_valid, 1'b0);
    check("arst_pressed", key_pressed, 1'b0);
    @(negedge clk);
    exp_q.push_back(4'h3);
    rst_n = 1'b1;
    wait_pressed(1'b1, "arst_press");
    check("arst_key", key_value, 4'h3);
    k_on = 1'b0;
    wait_pressed(1'b0, "arst_release");
    // long hold of '9'
`ifdef KEYPAD_REPEAT_EN
    repeat (3) exp_q.push_back(4'h9);
`endif
    press(4'b0010, 4'b0010, 4'h9, 68);
    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
